// File: rtl/gate_input_debouncer.sv
// Two-channel raw-input conditioner: 2-flop synchronizer plus debounce FSM per channel.
// Define EDGE_PULSE_EN to add registered one-cycle rise/fall pulses on each debounced output.
module gate_input_debouncer #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_raw,
    input  logic b_raw,
    output logic a_db,
    output logic b_db
`ifdef EDGE_PULSE_EN
    ,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
`endif
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0] raw_vec;
    logic [1:0] db_vec;
`ifdef EDGE_PULSE_EN
    logic [1:0] rise_vec;
    logic [1:0] fall_vec;
`endif

    assign raw_vec = {b_raw, a_raw};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic             s1_reg;
            logic             s2_reg;
            state_t           state_reg;
            state_t           state_next;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             db_reg;
            logic             db_next;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_reg    <= 1'b0;
                    s2_reg    <= 1'b0;
                    state_reg <= STABLE_LO;
                    cnt_reg   <= '0;
                    db_reg    <= 1'b0;
                end else begin
                    s1_reg    <= raw_vec[gi];
                    s2_reg    <= s1_reg;
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    db_reg    <= db_next;
                end
            end

            // Counter only ever counts toward CNT_MAX; any reversal of s2 resets it.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                db_next    = db_reg;
                case (state_reg)
                    STABLE_LO: begin
                        if (s2_reg) begin
                            state_next = WAIT_HI;
                            cnt_next   = CNT_ONE;
                        end else begin
                            cnt_next   = '0;
                        end
                    end
                    WAIT_HI: begin
                        if (!s2_reg) begin
                            state_next = STABLE_LO;
                            cnt_next   = '0;
                        end else if (cnt_reg == CNT_MAX) begin
                            state_next = STABLE_HI;
                            db_next    = 1'b1;
                            cnt_next   = '0;
                        end else begin
                            cnt_next   = cnt_reg + CNT_ONE;
                        end
                    end
                    STABLE_HI: begin
                        if (!s2_reg) begin
                            state_next = WAIT_LO;
                            cnt_next   = CNT_ONE;
                        end
                    end
                    WAIT_LO: begin
                        if (s2_reg) begin
                            state_next = STABLE_HI;
                            cnt_next   = '0;
                        end else if (cnt_reg == CNT_MAX) begin
                            state_next = STABLE_LO;
                            db_next    = 1'b0;
                            cnt_next   = '0;
                        end else begin
                            cnt_next   = cnt_reg + CNT_ONE;
                        end
                    end
                endcase
            end

            assign db_vec[gi] = db_reg;

`ifdef EDGE_PULSE_EN
            logic rise_reg;
            logic fall_reg;

            // Pulses land on the same edge as the db transition they mark.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rise_reg <= 1'b0;
                    fall_reg <= 1'b0;
                end else begin
                    rise_reg <= db_next & ~db_reg;
                    fall_reg <= ~db_next & db_reg;
                end
            end

            assign rise_vec[gi] = rise_reg;
            assign fall_vec[gi] = fall_reg;
`endif
        end
    endgenerate

    assign a_db = db_vec[0];
    assign b_db = db_vec[1];

`ifdef EDGE_PULSE_EN
    assign a_rise = rise_vec[0];
    assign a_fall = fall_vec[0];
    assign b_rise = rise_vec[1];
    assign b_fall = fall_vec[1];
`endif

endmodule

// File: tb/tb_gate_input_debouncer.sv
// Scoreboarded random/directed bench for gate_input_debouncer; reference model is a
// run-length rule on the synchronized input, one expected entry queued per clock edge.
module tb_gate_input_debouncer;

    localparam int DEB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic a_raw = 1'b0;
    logic b_raw = 1'b0;
    logic a_db;
    logic b_db;
`ifdef EDGE_PULSE_EN
    logic a_rise, a_fall, b_rise, b_fall;
`endif

    gate_input_debouncer #(.DEB_CYCLES(DEB), .CNT_W(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_raw  (a_raw),
        .b_raw  (b_raw),
        .a_db   (a_db),
        .b_db   (b_db)
`ifdef EDGE_PULSE_EN
        ,
        .a_rise (a_rise),
        .a_fall (a_fall),
        .b_rise (b_rise),
        .b_fall (b_fall)
`endif
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Expected word: {b_fall, a_fall, b_rise, a_rise, b_db, a_db}
    logic [5:0] exp_q[$];
    string      tag_q[$];

    // Model: two-sample delay line to the synchronized value, then a run length of
    // samples disagreeing with db; DEB+1 consecutive disagreements flip db.
    logic m_s1[2];
    logic m_s2[2];
    logic m_db[2];
    int   m_run[2];

    function automatic logic [5:0] actual_word();
        logic [5:0] w;
        w = {4'b0000, b_db, a_db};
`ifdef EDGE_PULSE_EN
        w[5:2] = {b_fall, a_fall, b_rise, a_rise};
`endif
        return w;
    endfunction

    function automatic logic [5:0] mask_word();
`ifdef EDGE_PULSE_EN
        return 6'b111111;
`else
        return 6'b000011;
`endif
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        logic [5:0] m;
        m = mask_word();
        vectors++;
        if ((act & m) !== (exp & m)) begin
            miscompares++;
            $display("FAIL %s: got {fall,rise,db}=%b required %b", name, act & m, exp & m);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_db[c] = 1'b0; m_run[c] = 0;
        end
    endtask

    // Drive raw levels for the coming edge and queue what the outputs must be after it.
    task automatic apply(input logic a, input logic b, input string tag);
        logic       raw[2];
        logic [1:0] rise, fall, db;
        raw[0] = a; raw[1] = b;
        a_raw = a; b_raw = b;
        for (int c = 0; c < 2; c++) begin
            rise[c] = 1'b0; fall[c] = 1'b0;
            if (m_s2[c] != m_db[c]) begin
                m_run[c]++;
                if (m_run[c] == DEB + 1) begin
                    m_db[c]  = ~m_db[c];
                    m_run[c] = 0;
                    rise[c]  = m_db[c];
                    fall[c]  = ~m_db[c];
                end
            end else begin
                m_run[c] = 0;
            end
            m_s2[c] = m_s1[c];
            m_s1[c] = raw[c];
            db[c]   = m_db[c];
        end
        exp_q.push_back({fall, rise, db});
        tag_q.push_back(tag);
    endtask

    task automatic step(input logic a, input logic b, input string tag);
        @(negedge clk);
        apply(a, b, tag);
    endtask

    task automatic run(input logic a, input logic b, input int n, input string tag);
        for (int i = 0; i < n; i++) step(a, b, tag);
    endtask

    // Monitor: the DUT presents an output word every active edge while out of reset.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                logic [5:0] e;
                string      t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check(t, actual_word(), e);
            end
        end
    end

    initial begin
        int hold_a, hold_b;
        logic lvl_a, lvl_b;

        model_reset();
        a_raw = 1'b1; b_raw = 1'b1;
        #1 rst_n = 1'b0;
        #1 check("async_reset", actual_word(), 6'b000000);
        repeat (2) @(posedge clk);
        #1 check("reset_hold", actual_word(), 6'b000000);

        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        apply(1'b1, 1'b1, "release_rise");
        run(1'b1, 1'b1, 9, "release_rise");
        run(1'b1, 1'b0, 10, "b_fall");
        run(1'b0, 1'b0, 10, "a_fall");
        run(1'b1, 1'b0, 3, "glitch3");
        run(1'b0, 1'b0, 10, "glitch3");
        run(1'b1, 1'b0, 5, "pulse5");
        run(1'b0, 1'b0, 12, "pulse5");
        step(1'b1, 1'b0, "bounce"); step(1'b0, 1'b0, "bounce");
        step(1'b1, 1'b0, "bounce"); step(1'b0, 1'b0, "bounce");
        run(1'b1, 1'b0, 10, "bounce");
        run(1'b1, 1'b1, 10, "b_rise");
        run(1'b0, 1'b0, 10, "both_fall");
        run(1'b1, 1'b1, 10, "simul_rise");
        run(1'b0, 1'b0, 10, "both_low");

        // Raw high five edges: FSM sits in WAIT_HI with cnt=3, then reset asynchronously.
        run(1'b1, 1'b1, 5, "pre_mid_reset");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("mid_reset_async", actual_word(), 6'b000000);
        repeat (2) @(posedge clk);
        #1 check("mid_reset_hold", actual_word(), 6'b000000);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        apply(1'b1, 1'b1, "post_reset_rise");
        run(1'b1, 1'b1, 9, "post_reset_rise");

        hold_a = 0; hold_b = 0; lvl_a = 1'b1; lvl_b = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (hold_a == 0) begin
                lvl_a  = 1'($urandom_range(0, 1));
                hold_a = $urandom_range(1, 2 * DEB + 3);
            end
            if (hold_b == 0) begin
                lvl_b  = 1'($urandom_range(0, 1));
                hold_b = $urandom_range(1, 2 * DEB + 3);
            end
            step(lvl_a, lvl_b, "random");
            hold_a--; hold_b--;
        end
        run(1'b0, 1'b0, 12, "drain");

        @(posedge clk);
        #3;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending entries required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
